// File: rtl/reg_mask_encoder_pkg.sv
// Shared constants, types and FSM states for the register mask encoder.
package reg_enc_pkg;
  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [NUM_REGS-1:0]  reg_mask_t;

  typedef enum logic {IDLE, SCAN} enc_state_t;
endpackage

// File: rtl/reg_mask_encoder_if.sv
// Mask-in / index-out handshake bundle between the writeback logic and the encoder.
interface reg_mask_encoder_if #(
  parameter int N = reg_enc_pkg::NUM_REGS
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]     in_mask;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [IDX_W:0]   out_seq;

  // Upstream producer plus downstream consumer side.
  modport master (
    output in_mask, in_valid, out_ready,
    input  in_ready, out_idx, out_valid, out_last, out_seq
  );

  // Encoder side.
  modport slave (
    input  in_mask, in_valid, out_ready,
    output in_ready, out_idx, out_valid, out_last, out_seq
  );
endinterface

// File: rtl/reg_mask_encoder_lse.sv
// Combinational lowest-set-bit encoder with nonzero and single-bit flags.
module lowest_set_encoder #(
  parameter int N     = 32,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o,
  output logic             single_o
);

  // Scan high-to-low so the lowest set bit wins; all-zero input yields 0.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign any_o    = |vec_i;
  assign single_o = any_o && ((vec_i & (vec_i - 1'b1)) == '0);

endmodule

// File: rtl/reg_mask_encoder.sv
// Serialises a register-select mask into one binary index per output handshake,
// lowest bit first, with an ordinal and a last-flag for each index.
module reg_mask_encoder
  import reg_enc_pkg::*;
#(
  parameter int N     = NUM_REGS,
  parameter int IDX_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  reg_mask_encoder_if.slave bus
);

  enc_state_t       state_q, state_d;
  logic [N-1:0]     pend_q, pend_d;
  logic [IDX_W:0]   seq_q, seq_d;

  logic [IDX_W-1:0] low_idx;
  logic             pend_any;
  logic             pend_single;
  logic             in_rdy;
  logic             out_vld;

  lowest_set_encoder #(.N(N), .IDX_W(IDX_W)) u_lse (
    .vec_i   (pend_q),
    .idx_o   (low_idx),
    .any_o   (pend_any),
    .single_o(pend_single)
  );

  // State, pending mask and ordinal registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      seq_q   <= seq_d;
    end
  end

  // Next-state: accept a mask in IDLE, retire one bit per output transfer in SCAN.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    seq_d   = seq_q;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    case (state_q)
      IDLE: begin
        in_rdy = !reset;
        // A zero mask is consumed and dropped without leaving IDLE.
        if (bus.in_valid && bus.in_mask != '0) begin
          pend_d  = bus.in_mask;
          seq_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        out_vld = pend_any;
        if (bus.out_ready && pend_any) begin
          pend_d[low_idx] = 1'b0;
          seq_d           = seq_q + 1'b1;
          if (pend_single) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_idx   = low_idx;
  assign bus.out_last  = out_vld && pend_single;
  assign bus.out_seq   = seq_q;

endmodule

// File: tb/tb_reg_mask_encoder.sv
// Bench for reg_mask_encoder: vector table plus hand sequences, outputs checked
// against a scoreboard of expected {idx, seq, last} pushed at stimulus time.
module tb_reg_mask_encoder;

  logic clk;
  logic reset;

  reg_mask_encoder_if #(.N(32)) bus ();

  reg_mask_encoder #(.N(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int seq;
    bit last;
  } exp_t;

  typedef struct {
    logic [31:0] mask;
    int          busy;   // cycles in_ready stays low after acceptance
  } vec_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Reference model: expected index stream for a mask, lowest bit first.
  function automatic void push_model(input logic [31:0] m);
    int cnt;
    int s;
    exp_t e;
    cnt = 0;
    for (int i = 0; i < 32; i++) if (m[i]) cnt++;
    s = 0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) begin
        e.idx  = i;
        e.seq  = s;
        e.last = (s == cnt - 1);
        sb.push_back(e);
        s++;
      end
    end
  endfunction

  // Output monitor: every valid output must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else if (bus.out_ready) begin
        exp_t e;
        e = sb.pop_front();
        chk("out_idx", int'(bus.out_idx), e.idx);
        chk("out_seq", int'(bus.out_seq), e.seq);
        chk("out_last", int'(bus.out_last), int'(e.last));
      end
    end
  end

  // Waits for in_ready, presents one mask for a single accepted cycle.
  task automatic send(input logic [31:0] m);
    int n;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", 0, 1);
    bus.in_mask  = m;
    bus.in_valid = 1'b1;
    push_model(m);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_mask  = '0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
    end
    if (n >= 100) chk({name, "_idle_timeout"}, 0, 1);
    chk({name, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int  c;
    bit  first;
    c     = 0;
    first = 1'b1;
    send(v.mask);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (first) chk($sformatf("v%0d_first_valid", k), int'(bus.out_valid), int'(v.mask != 0));
      first = 1'b0;
      if (bus.in_ready) break;
      c++;
    end
    chk($sformatf("v%0d_busy_cycles", k), c, v.busy);
    chk($sformatf("v%0d_sb_empty", k), sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{mask: 32'h0000_0100, busy: 1};
    vecs[1] = '{mask: 32'h8000_0025, busy: 4};
    vecs[2] = '{mask: 32'h0000_0000, busy: 0};
    vecs[3] = '{mask: 32'h0000_0001, busy: 1};
    vecs[4] = '{mask: 32'hFFFF_FFFF, busy: 32};
    vecs[5] = '{mask: 32'hAAAA_5555, busy: 16};
    vecs[6] = '{mask: 32'h8000_0000, busy: 1};

    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    bus.in_mask  = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_out_idx", int'(bus.out_idx), 0);
    chk("rst_out_seq", int'(bus.out_seq), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(bus.in_ready), 1);

    // Table-driven vectors
    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

    // Back-pressure: index 1 held while out_ready is low
    bus.out_ready = 1'b0;
    send(32'h0000_0006);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("bp_valid", int'(bus.out_valid), 1);
      chk("bp_idx", int'(bus.out_idx), 1);
      chk("bp_seq", int'(bus.out_seq), 0);
      chk("bp_last", int'(bus.out_last), 0);
      chk("bp_in_ready", int'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_idle("bp");

    // Reset mid-scan after index 13 has transferred
    send(32'h0000_F000);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("mid_sb_remaining", sb.size(), 2);
    sb.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_last", int'(bus.out_last), 0);
    chk("mid_rst_idx", int'(bus.out_idx), 0);
    chk("mid_rst_seq", int'(bus.out_seq), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_post_in_ready", int'(bus.in_ready), 1);
    chk("mid_post_valid", int'(bus.out_valid), 0);
    send(32'h0000_0004);
    wait_idle("mid_follow");

    chk("final_sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_mask_encoder.md
Name: reg_mask_encoder

Overview:
- Converts one-hot and multi-hot register-select masks back into binary register indices. It is the inverse of the register-file address decoders.
- A latched mask is scanned lowest-bit-first. One index is emitted per output handshake.
- Sits between the writeback/forwarding logic and the 32x64 register file. It serialises multi-register operations (e.g. LDM/STM-style register lists) into single-address register-file accesses.

Parameters:
- N, 32, mask width / number of registers; power of 2, minimum 2.
- IDX_W, $clog2(N), width of the emitted index.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_mask  input  N  register-select mask.
- in_valid  input  1  in_mask is valid.
- in_ready  output  1  block can accept a mask.
- out_idx  output  IDX_W  index of the lowest set bit still pending.
- out_valid  output  1  out_idx is valid.
- out_ready  input  1  consumer accepts out_idx.
- out_last  output  1  out_idx is the final pending bit of the current mask.
- out_seq  output  IDX_W+1  zero-based ordinal of out_idx within the current mask.

Behaviour:
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SCAN: in_ready=0, out_valid=1.
- Reset, sampled at a clk edge while reset=1:
  - State goes to IDLE; pending mask register and out_seq counter clear to 0.
  - in_ready=0 while reset is high, 1 on the first cycle after reset deasserts.
  - out_valid=0 and out_last=0.
  - out_idx=0 and out_seq=0.
- Input acceptance:
  - A transfer occurs when in_valid && in_ready at a clk edge.
  - Nonzero in_mask: latch it into the pending register, clear out_seq, go to SCAN.
  - Zero in_mask: accept and drop it; stay in IDLE; no output is produced.
- Latency: first out_valid appears on the cycle after acceptance (1 cycle).
- out_idx: combinational priority encode (lowest set bit) of the pending register. It is stable while out_valid && !out_ready.
- out_last: 1 when exactly one bit is pending, i.e. (pending & (pending-1)) == 0.
- Output transfer, when out_valid && out_ready at a clk edge:
  - Clear bit out_idx in the pending register.
  - Increment out_seq.
  - If out_last, go to IDLE; out_seq clears on the next acceptance.
- Back-pressure: with out_ready=0, all outputs hold indefinitely and no state changes.
- No same-cycle turnaround. After the last output handshake, in_ready rises on the next cycle. A full mask of K set bits therefore occupies K+1 cycles minimum between acceptances.
- A full mask (all N bits set) emits 0..N-1 in ascending order. The last transfer has out_seq=N-1 and out_last=1.
- in_mask/in_valid are ignored in SCAN; the upstream must hold them.
- Reset mid-SCAN: the pending mask is discarded, with no further outputs. The next accepted mask starts clean.
- No X propagation: out_idx=0 whenever the pending register is 0.

Decomposition:
- Package reg_enc_pkg holds:
  - constants NUM_REGS=32 and REG_IDX_W=5;
  - typedef reg_idx_t = logic [REG_IDX_W-1:0];
  - typedef reg_mask_t = logic [NUM_REGS-1:0];
  - enum enc_state_t {IDLE, SCAN}.
- Sub-module lowest_set_encoder, combinational:
  - Parameterised by N.
  - Outputs index, any (nonzero flag) and single (exactly-one-bit flag).
  - Instantiated once on the pending register; independently testable.

Test Plan:
- Single bit:
  - Stimulus: in_mask=32'h0000_0100, out_ready held 1.
  - Required: one cycle after accept, out_idx=8, out_last=1, out_seq=0; in_ready=1 on the following cycle.
- Multi-bit ordering:
  - Stimulus: in_mask=32'h8000_0025, out_ready=1.
  - Required: out_idx sequence 0,2,5,31 on consecutive cycles; out_seq 0..3; out_last only on 31.
- Back-pressure:
  - Stimulus: in_mask=32'h0000_0006, out_ready=0 for 4 cycles, then 1.
  - Required: out_idx=1 held stable for all 4 cycles, then 1 followed by 2 is emitted.
- Zero mask:
  - Stimulus: in_mask=0 accepted.
  - Required: out_valid never asserts; in_ready stays 1.
  - Follow-up: the next in_mask=32'h1 emits out_idx=0.
- Full mask:
  - Stimulus: in_mask=32'hFFFF_FFFF, out_ready=1.
  - Required: 32 outputs 0..31; out_seq ends at 31; in_ready back after 33 cycles from acceptance.
- Reset mid-scan:
  - Stimulus: in_mask=32'h0000_F000; assert reset after out_idx=13 has transferred.
  - Required: outputs cleared the next cycle, no indices 14/15 emitted; a subsequent in_mask=32'h4 emits 2 with out_seq=0.
